// File: rtl/stl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : stl_decode_stage
// Brief    : RV64 instruction decode stage. Classifies the major opcode into
//            a functional-unit type and an immediate type, builds the
//            sign-extended immediate, and buffers results in a 2-entry skid
//            buffer so in_ready is a pure register output.
// Revision : 1.0 - initial release
// ============================================================================
module stl_decode_stage #(
    parameter int XLEN     = 64,
    parameter int INST_LEN = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [INST_LEN-1:0] in_inst,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [INST_LEN-1:0] out_inst,
    output logic [1:0]          out_fu,
    output logic [2:0]          out_imm_type,
    output logic [XLEN-1:0]     out_imm,
    output logic                out_illegal
);

    // Functional-unit codes
    localparam logic [1:0] c_fu_alu = 2'd0;
    localparam logic [1:0] c_fu_lsu = 2'd1;
    localparam logic [1:0] c_fu_bru = 2'd2;
    localparam logic [1:0] c_fu_csr = 2'd3;

    // Immediate-type codes
    localparam logic [2:0] c_imm_none = 3'd0;
    localparam logic [2:0] c_imm_i    = 3'd1;
    localparam logic [2:0] c_imm_s    = 3'd2;
    localparam logic [2:0] c_imm_u    = 3'd3;
    localparam logic [2:0] c_imm_j    = 3'd4;
    localparam logic [2:0] c_imm_b    = 3'd5;

    // Major opcodes recognised by the decode table
    localparam logic [6:0] c_op_lui      = 7'b0110111;
    localparam logic [6:0] c_op_auipc    = 7'b0010111;
    localparam logic [6:0] c_op_jal      = 7'b1101111;
    localparam logic [6:0] c_op_jalr     = 7'b1100111;
    localparam logic [6:0] c_op_branch   = 7'b1100011;
    localparam logic [6:0] c_op_load     = 7'b0000011;
    localparam logic [6:0] c_op_store    = 7'b0100011;
    localparam logic [6:0] c_op_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_op       = 7'b0110011;
    localparam logic [6:0] c_op_op_imm32 = 7'b0011011;
    localparam logic [6:0] c_op_op32     = 7'b0111011;
    localparam logic [6:0] c_op_system   = 7'b1110011;
    localparam logic [6:0] c_op_misc_mem = 7'b0001111;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [INST_LEN-1:0] inst;
        logic [1:0]          fu;
        logic [2:0]          imm_type;
        logic [XLEN-1:0]     imm;
        logic                illegal;
    } entry_t;

    entry_t r_m;
    entry_t r_k;
    logic   r_m_valid;
    logic   r_k_valid;

    entry_t w_dec;
    logic   w_in_fire;
    logic   w_out_fire;
    logic   w_sign;

    assign w_sign     = in_inst[31];
    assign in_ready   = ~r_k_valid;
    assign out_valid  = r_m_valid;
    assign w_in_fire  = in_valid & ~r_k_valid;
    assign w_out_fire = r_m_valid & out_ready;

    // Keyed opcode lookup plus immediate assembly; table misses are illegal with no immediate
    always_comb begin
        w_dec          = '0;
        w_dec.pc       = in_pc;
        w_dec.inst     = in_inst;
        w_dec.fu       = c_fu_alu;
        w_dec.imm_type = c_imm_none;
        w_dec.illegal  = 1'b0;
        case (in_inst[6:0])
            c_op_lui, c_op_auipc:         w_dec.imm_type = c_imm_u;
            c_op_jal:       begin w_dec.fu = c_fu_bru; w_dec.imm_type = c_imm_j; end
            c_op_jalr:      begin w_dec.fu = c_fu_bru; w_dec.imm_type = c_imm_i; end
            c_op_branch:    begin w_dec.fu = c_fu_bru; w_dec.imm_type = c_imm_b; end
            c_op_load:      begin w_dec.fu = c_fu_lsu; w_dec.imm_type = c_imm_i; end
            c_op_store:     begin w_dec.fu = c_fu_lsu; w_dec.imm_type = c_imm_s; end
            c_op_op_imm, c_op_op_imm32:   w_dec.imm_type = c_imm_i;
            c_op_op, c_op_op32, c_op_misc_mem: w_dec.imm_type = c_imm_none;
            c_op_system:    begin w_dec.fu = c_fu_csr; w_dec.imm_type = c_imm_i; end
            default:                      w_dec.illegal  = 1'b1;
        endcase
        case (w_dec.imm_type)
            c_imm_i: w_dec.imm = {{(XLEN-12){w_sign}}, in_inst[31:20]};
            c_imm_s: w_dec.imm = {{(XLEN-12){w_sign}}, in_inst[31:25], in_inst[11:7]};
            c_imm_b: w_dec.imm = {{(XLEN-13){w_sign}}, in_inst[31], in_inst[7],
                                  in_inst[30:25], in_inst[11:8], 1'b0};
            c_imm_u: w_dec.imm = {{(XLEN-32){w_sign}}, in_inst[31:12], 12'b0};
            c_imm_j: w_dec.imm = {{(XLEN-21){w_sign}}, in_inst[31], in_inst[19:12],
                                  in_inst[20], in_inst[30:21], 1'b0};
            default: w_dec.imm = '0;
        endcase
    end

    // Skid-buffer update: M feeds the output, K absorbs one entry while M stalls
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m       <= '0;
            r_k       <= '0;
            r_m_valid <= 1'b0;
            r_k_valid <= 1'b0;
        end else if (flush) begin
            // A same-cycle output fire needs no action; any input fire is dropped
            r_m_valid <= 1'b0;
            r_k_valid <= 1'b0;
        end else if (w_out_fire) begin
            if (r_k_valid) begin
                r_m       <= r_k;
                r_k_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_m       <= w_dec;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (!r_m_valid) begin
            if (w_in_fire) begin
                r_m       <= w_dec;
                r_m_valid <= 1'b1;
            end
        end else if (w_in_fire) begin
            r_k       <= w_dec;
            r_k_valid <= 1'b1;
        end
    end

    assign out_pc       = r_m.pc;
    assign out_inst     = r_m.inst;
    assign out_fu       = r_m.fu;
    assign out_imm_type = r_m.imm_type;
    assign out_imm      = r_m.imm;
    assign out_illegal  = r_m.illegal;

endmodule
`default_nettype wire

// File: tb/tb_stl_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_stl_decode_stage
// Brief    : Directed self-checking bench for stl_decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stl_decode_stage;

    localparam int XLEN     = 64;
    localparam int INST_LEN = 32;

    logic                clock = 1'b0;
    logic                reset;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic [INST_LEN-1:0] in_inst;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [INST_LEN-1:0] out_inst;
    logic [1:0]          out_fu;
    logic [2:0]          out_imm_type;
    logic [XLEN-1:0]     out_imm;
    logic                out_illegal;

    int n_vec = 0;
    int n_err = 0;

    stl_decode_stage #(.XLEN(XLEN), .INST_LEN(INST_LEN)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_fu(out_fu), .out_imm_type(out_imm_type),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clock = ~clock;

    // Advance past the next rising edge so outputs are settled
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [INST_LEN-1:0] inst);
        in_valid = v;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, '0, '0);
        tick(); tick();
        reset = 1'b0;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL reset_hs: got valid/ready %b expected 01", {out_valid, in_ready});
        end
        n_vec++;
        if ({out_pc, out_inst, out_fu, out_imm_type, out_imm, out_illegal} !== '0) begin
            n_err++; $display("FAIL reset_data: got pc=%h inst=%h imm=%h expected all zero", out_pc, out_inst, out_imm);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 64'h0000_0000_8000_0000, 32'hFFF0_0093);
        tick();
        drive(1'b0, '0, '0);
        n_vec++;
        if ({out_valid, out_fu, out_imm_type, out_illegal} !== {1'b1, 2'd0, 3'd1, 1'b0}) begin
            n_err++; $display("FAIL addi_ctl: got v=%b fu=%0d t=%0d ill=%b expected v=1 fu=0 t=1 ill=0",
                              out_valid, out_fu, out_imm_type, out_illegal);
        end
        n_vec++;
        if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFF || out_pc !== 64'h8000_0000 || out_inst !== 32'hFFF0_0093) begin
            n_err++; $display("FAIL addi_data: got imm=%h pc=%h inst=%h expected imm=ffffffffffffffff pc=80000000 inst=fff00093",
                              out_imm, out_pc, out_inst);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL addi_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [4];
        logic [63:0] imms  [4];
        logic [1:0]  fus   [4];
        logic [2:0]  types [4];
        insts = '{32'h8000_00B7, 32'hFE11_2E23, 32'hFE00_0EE3, 32'hFF5F_F0EF};
        imms  = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFC,
                  64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFF4};
        fus   = '{2'd0, 2'd1, 2'd2, 2'd2};
        types = '{3'd3, 3'd2, 3'd5, 3'd4};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h100 + 64'(4 * i), insts[i]);
            tick();
            n_vec++;
            if ({out_valid, in_ready, out_fu, out_imm_type} !== {1'b1, 1'b1, fus[i], types[i]}
                || out_imm !== imms[i] || out_pc !== 64'h100 + 64'(4 * i) || out_inst !== insts[i]) begin
                n_err++; $display("FAIL stream[%0d]: got v=%b r=%b fu=%0d t=%0d imm=%h pc=%h expected v=1 r=1 fu=%0d t=%0d imm=%h pc=%h",
                                  i, out_valid, in_ready, out_fu, out_imm_type, out_imm, out_pc,
                                  fus[i], types[i], imms[i], 64'h100 + 64'(4 * i));
            end
        end
        drive(1'b0, '0, '0);
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 64'hA0, 32'h0010_0093);
        tick();
        n_vec++;
        if ({out_valid, in_ready} !== 2'b11 || out_pc !== 64'hA0) begin
            n_err++; $display("FAIL stall_m: got v=%b r=%b pc=%h expected v=1 r=1 pc=a0", out_valid, in_ready, out_pc);
        end
        drive(1'b1, 64'hB0, 32'h0020_0113);
        tick();
        n_vec++;
        if ({out_valid, in_ready} !== 2'b10 || out_pc !== 64'hA0) begin
            n_err++; $display("FAIL stall_k: got v=%b r=%b pc=%h expected v=1 r=0 pc=a0", out_valid, in_ready, out_pc);
        end
        drive(1'b1, 64'hC0, 32'h0030_0193);
        tick();
        n_vec++;
        if (in_ready !== 1'b0 || out_pc !== 64'hA0 || out_inst !== 32'h0010_0093 || out_imm !== 64'd1) begin
            n_err++; $display("FAIL stall_hold: got r=%b pc=%h inst=%h imm=%h expected r=0 pc=a0 inst=00100093 imm=1",
                              in_ready, out_pc, out_inst, out_imm);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if ({out_valid, in_ready} !== 2'b11 || out_pc !== 64'hB0 || out_imm !== 64'd2) begin
            n_err++; $display("FAIL stall_k_out: got v=%b r=%b pc=%h imm=%h expected v=1 r=1 pc=b0 imm=2",
                              out_valid, in_ready, out_pc, out_imm);
        end
        tick();
        drive(1'b0, '0, '0);
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 64'hC0 || out_imm !== 64'd3) begin
            n_err++; $display("FAIL stall_c_out: got v=%b pc=%h imm=%h expected v=1 pc=c0 imm=3", out_valid, out_pc, out_imm);
        end
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [2];
        bad = '{32'h0000_007F, 32'h0000_0000};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h200, bad[i]);
            tick();
            n_vec++;
            if ({out_valid, out_illegal, out_fu, out_imm_type} !== {1'b1, 1'b1, 2'd0, 3'd0} || out_imm !== '0) begin
                n_err++; $display("FAIL illegal[%0d]: got v=%b ill=%b fu=%0d t=%0d imm=%h expected v=1 ill=1 fu=0 t=0 imm=0",
                                  i, out_valid, out_illegal, out_fu, out_imm_type, out_imm);
            end
        end
        drive(1'b0, '0, '0);
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 64'h300, 32'h0010_0093);
        tick();
        drive(1'b1, 64'h304, 32'h0020_0113);
        tick();
        flush = 1'b1;
        drive(1'b1, 64'h308, 32'h0030_0193);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL flush: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("FAIL flush_ghost[%0d]: got out_valid=%b expected 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(1'b1, 64'h400, 32'hFF5F_F0EF);
        tick();
        drive(1'b1, 64'h404, 32'hFE11_2E23);
        tick();
        drive(1'b0, '0, '0);
        n_vec++;
        if ({out_valid, in_ready, out_fu} !== {1'b1, 1'b0, 2'd2}) begin
            n_err++; $display("FAIL prereset_full: got v=%b r=%b fu=%0d expected v=1 r=0 fu=2", out_valid, in_ready, out_fu);
        end
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        n_vec++;
        if ({out_valid, in_ready} !== 2'b01
            || {out_pc, out_inst, out_fu, out_imm_type, out_imm, out_illegal} !== '0) begin
            n_err++; $display("FAIL reset_full: got v=%b r=%b pc=%h inst=%h fu=%0d imm=%h expected v=0 r=1 all zero",
                              out_valid, in_ready, out_pc, out_inst, out_fu, out_imm);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_ghost: got out_valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_flush();
        test_reset_full();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
